// File: rtl/vga_pattern_gen_if.sv
// Pixel-side bundle of the VGA pattern generator: pattern controls in, sync/colour out.
// The generator uses the master modport; the board pins or a bench use the slave modport.
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 1
);
    logic [1:0]           mode;
    logic [3*COLOR_W-1:0] sw;
    logic                 hsync;
    logic                 vsync;
    logic                 video_on;
    logic [3*COLOR_W-1:0] rgb;
    logic                 frame_start;

    modport master (
        input  mode,
        input  sw,
        output hsync,
        output vsync,
        output video_on,
        output rgb,
        output frame_start
    );

    modport slave (
        output mode,
        output sw,
        input  hsync,
        input  vsync,
        input  video_on,
        input  rgb,
        input  frame_start
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator with its own sync timing: solid, colour bars, checkerboard, bouncing box.
// Optional build macro VGA_BORDER_EN forces a one-pixel white border around the visible area.
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COLOR_W  = 1,
    parameter int TICK_DIV = 2,
    parameter int BOX_SIZE = 32
) (
    input  logic              clk,
    input  logic              reset,
    vga_pattern_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RGB_W   = 3 * COLOR_W;
    localparam int BX_MAX  = H_ACTIVE - BOX_SIZE;
    localparam int BY_MAX  = V_ACTIVE - BOX_SIZE;

    typedef enum logic {
        DIR_POS,
        DIR_NEG
    } dir_t;

    logic [TW-1:0]    tick_cnt;
    logic             p_tick;
    logic [HW-1:0]    h;
    logic [VW-1:0]    v;
    logic             h_last;
    logic             v_last;
    logic             frame_end;

    logic [1:0]       mode_reg;
    logic [RGB_W-1:0] sw_reg;

    logic [HW-1:0]    bx;
    logic [VW-1:0]    by;
    dir_t             dx;
    dir_t             dy;

    logic             hsync_d;
    logic             vsync_d;
    logic             video_d;
    logic [RGB_W-1:0] pattern;
    logic [RGB_W-1:0] rgb_d;
    logic [HW+2:0]    bar_num;
    logic [2:0]       bar_idx;
    logic             in_box;

    logic             hsync_q;
    logic             vsync_q;
    logic             video_q;
    logic [RGB_W-1:0] rgb_q;
    logic             frame_start_q;

    assign p_tick    = (tick_cnt == TW'(TICK_DIV - 1));
    assign h_last    = (h == HW'(H_TOTAL - 1));
    assign v_last    = (v == VW'(V_TOTAL - 1));
    assign frame_end = p_tick && h_last && v_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (p_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h <= '0;
            v <= '0;
        end else if (p_tick) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    // Mode is only taken at the frame wrap so a frame is never drawn with two patterns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_reg        <= '0;
            mode_reg      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            sw_reg        <= bus.sw;
            frame_start_q <= frame_end;
            if (frame_end) begin
                mode_reg <= bus.mode;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bx <= '0;
            by <= '0;
            dx <= DIR_POS;
            dy <= DIR_POS;
        end else if (frame_end) begin
            if (dx == DIR_POS) begin
                if (bx == HW'(BX_MAX)) begin
                    dx <= DIR_NEG;
                    bx <= bx - HW'(1);
                end else begin
                    bx <= bx + HW'(1);
                end
            end else begin
                if (bx == '0) begin
                    dx <= DIR_POS;
                    bx <= bx + HW'(1);
                end else begin
                    bx <= bx - HW'(1);
                end
            end
            if (dy == DIR_POS) begin
                if (by == VW'(BY_MAX)) begin
                    dy <= DIR_NEG;
                    by <= by - VW'(1);
                end else begin
                    by <= by + VW'(1);
                end
            end else begin
                if (by == '0) begin
                    dy <= DIR_POS;
                    by <= by + VW'(1);
                end else begin
                    by <= by - VW'(1);
                end
            end
        end
    end

    always_comb begin
        hsync_d = !((h >= HW'(H_ACTIVE + H_FP)) && (h <= HW'(H_ACTIVE + H_FP + H_SYNC - 1)));
        vsync_d = !((v >= VW'(V_ACTIVE + V_FP)) && (v <= VW'(V_ACTIVE + V_FP + V_SYNC - 1)));
        video_d = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    end

    // Bar index widens h by 3 bits before the divide so h*8 cannot overflow.
    always_comb begin
        bar_num = {h, 3'b000};
        bar_idx = 3'(bar_num / (HW + 3)'(H_ACTIVE));
        in_box  = ({1'b0, h} >= {1'b0, bx}) &&
                  ({1'b0, h} <  ({1'b0, bx} + (HW + 1)'(BOX_SIZE))) &&
                  ({1'b0, v} >= {1'b0, by}) &&
                  ({1'b0, v} <  ({1'b0, by} + (VW + 1)'(BOX_SIZE)));
        pattern = '0;
        case (mode_reg)
            2'd0: pattern = sw_reg;
            2'd1: pattern = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
            2'd2: pattern = (h[5] ^ v[5]) ? ~sw_reg : sw_reg;
            default: pattern = in_box ? sw_reg : '0;
        endcase
`ifdef VGA_BORDER_EN
        if ((h == '0) || (h == HW'(H_ACTIVE - 1)) || (v == '0) || (v == VW'(V_ACTIVE - 1))) begin
            pattern = '1;
        end
`endif
        rgb_d = video_d ? pattern : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b0;
            rgb_q   <= '0;
        end else if (p_tick) begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            rgb_q   <= rgb_d;
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.video_on    = video_q;
    assign bus.rgb         = rgb_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized bench for vga_pattern_gen on a shrunken raster, against a closed-form pixel model.
module tb_vga_pattern_gen;
    localparam int HA = 40, HFP = 2, HS = 4, HBP = 2;
    localparam int VA = 36, VFP = 1, VS = 2, VBP = 1;
    localparam int CW = 1, TD = 2, BOX = 32;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int RGB_W = 3 * CW;
    localparam int MAXF = 40;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    vga_pattern_gen_if #(.COLOR_W(CW)) bus ();

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .COLOR_W(CW), .TICK_DIV(TD), .BOX_SIZE(BOX)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Triangle wave: 0,1..r,r-1..0,1.. indexed by frame count.
    function automatic int tri_pos(input int f, input int r);
        int p;
        p = f % (2 * r);
        return (p <= r) ? p : 2 * r - p;
    endfunction

    function automatic logic [RGB_W-1:0] model_pix(input int h, input int v, input int md,
                                                   input logic [RGB_W-1:0] s, input int frames);
        logic [RGB_W-1:0] res;
        int b, x0, y0;
        res = '0;
`ifdef VGA_BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) begin
            res = '1;
            return res;
        end
`endif
        case (md)
            0: res = s;
            1: begin
                b = h * 8 / HA;
                for (int c = 0; c < 3; c++)
                    if (((b >> c) & 1) == 1) res[c*CW +: CW] = '1;
            end
            2: res = (((h / 32) + (v / 32)) % 2 == 1) ? ~s : s;
            default: begin
                x0 = tri_pos(frames, HA - BOX);
                y0 = tri_pos(frames, VA - BOX);
                if (h >= x0 && h < x0 + BOX && v >= y0 && v < y0 + BOX) res = s;
            end
        endcase
        return res;
    endfunction

    // Reference state: edges since release, frames wrapped, latched mode, sampled switch.
    int               m_edges;
    int               m_frames;
    int               m_mode;
    logic [RGB_W-1:0] m_sw;
    logic             e_hs, e_vs, e_vid, e_fs;
    logic [RGB_W-1:0] e_rgb;

    task automatic model_reset();
        m_edges = 0; m_frames = 0; m_mode = 0; m_sw = '0;
        e_hs = 1'b1; e_vs = 1'b1; e_vid = 1'b0; e_fs = 1'b0; e_rgb = '0;
    endtask

    initial model_reset();
    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        int k, q, h, v;
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_edges++;
            e_fs = 1'b0;
            if (m_edges % TD == 0) begin
                k = m_edges / TD;
                q = (k - 1) % FT;
                h = q % HT;
                v = q / HT;
                e_hs  = !(h >= HA + HFP && h < HA + HFP + HS);
                e_vs  = !(v >= VA + VFP && v < VA + VFP + VS);
                e_vid = (h < HA) && (v < VA);
                e_rgb = e_vid ? model_pix(h, v, m_mode, m_sw, m_frames) : '0;
                if (q == FT - 1) begin
                    e_fs = 1'b1;
                    m_mode = int'(bus.mode);
                    m_frames++;
                end
            end
            m_sw = bus.sw;
        end
        check_eq("outputs", 32'({bus.hsync, bus.vsync, bus.video_on, bus.frame_start, bus.rgb}),
                 32'({e_hs, e_vs, e_vid, e_fs, e_rgb}));
    end

    task automatic run_clks(input int n, input bit rnd_mode);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (n_fail > MAXF) return;
            if (rnd_mode && $urandom_range(0, 399) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) bus.sw = RGB_W'($urandom);
        end
    endtask

    task automatic wait_fs();
        int i;
        for (i = 0; i < 2 * FT * TD; i++) begin
            @(negedge clk);
            if (bus.frame_start) break;
        end
        if (i == 2 * FT * TD) check_eq("wait_frame_start", 32'(0), 32'(1));
    endtask

    initial begin
        int hs_lo, vs_lo, fs_cnt, line_hs, cnt;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        bus.mode = 2'd0;
        bus.sw   = RGB_W'(3'b101);
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Sync pulse widths and frame period over one full frame window.
        wait_fs();
        hs_lo = 0; vs_lo = 0; fs_cnt = 0; line_hs = 0;
        for (int i = 0; i < FT * TD; i++) begin
            @(negedge clk);
            if (!bus.hsync) hs_lo++;
            if (!bus.vsync) vs_lo++;
            if (bus.frame_start) fs_cnt++;
            if (i < HT * TD && !bus.hsync) line_hs++;
        end
        check_eq("hsync_low_per_line", 32'(line_hs), 32'(HS * TD));
        check_eq("hsync_low_per_frame", 32'(hs_lo), 32'(VT * HS * TD));
        check_eq("vsync_low_per_frame", 32'(vs_lo), 32'(VS * HT * TD));
        check_eq("frame_start_per_frame", 32'(fs_cnt), 32'(1));

        run_clks(6 * FT * TD, 1'b1);

        // Mid-frame switch into box mode, then long enough for the box to bounce.
        repeat (777) @(negedge clk);
        bus.mode = 2'd3;
        run_clks(8 * FT * TD, 1'b0);

        // Asynchronous reset part-way through a frame.
        wait_fs();
        repeat ((15 * HT + 20) * TD) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_hsync", 32'(bus.hsync), 32'(1));
        check_eq("rst_vsync", 32'(bus.vsync), 32'(1));
        check_eq("rst_video_on", 32'(bus.video_on), 32'(0));
        check_eq("rst_rgb", 32'(bus.rgb), 32'(0));
        check_eq("rst_frame_start", 32'(bus.frame_start), 32'(0));
        repeat (3) @(negedge clk);
        bus.mode = 2'd0;
        bus.sw   = '0;
        rst_n    = 1'b1;
        cnt = 0;
        while (cnt < 2 * FT * TD) begin
            @(posedge clk);
            cnt++;
            #1;
            if (bus.frame_start) break;
        end
        check_eq("first_frame_start_latency", 32'(cnt), 32'(FT * TD));

        run_clks(FT * TD + 100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised VGA test-pattern generator; successor to the fixed switch-colour test block.
- Owns its own sync timing counters, so no external sync unit is needed.
- Supports configurable colour depth, pixel-clock divide, and four display modes: solid, colour bars, checkerboard, bouncing box.
- Sits directly in front of the board DAC/VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- COLOR_W, 1, bits per colour channel
- TICK_DIV, 2, clk cycles per pixel (>=1)
- BOX_SIZE, 32, bouncing-box edge length (pixels)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mode  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 box
- sw  in  3*COLOR_W  user colour {R,G,B}
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_on  out  1  high in the visible region
- rgb  out  3*COLOR_W  pixel colour {R,G,B}
- frame_start  out  1  one-clk pulse when the frame wraps

Behaviour:
- Reset (reset=0, asynchronous): all counters 0, hsync=1, vsync=1, video_on=0, rgb=0, frame_start=0, mode_reg=0, sw_reg=0, box at (0,0) with direction +x,+y.
- Frame totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Pixel tick:
  - tick counter counts 0..TICK_DIV-1; p_tick is asserted when it equals TICK_DIV-1.
  - With TICK_DIV=1, p_tick is asserted every clk.
- Counters:
  - On p_tick, h advances 0..H_TOTAL-1 and wraps to 0.
  - On h wrap, v advances 0..V_TOTAL-1 and wraps to 0.
- Sync and video_on, computed from the current (h,v):
  - hsync low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - video_on = (h<H_ACTIVE) && (v<V_ACTIVE).
- Output register:
  - hsync, vsync, video_on and rgb are registered together on p_tick from the same (h,v).
  - They are mutually aligned and lag the counters by one pixel.
  - They hold between ticks.
- rgb is 0 whenever the registered video_on is 0.
- sw_reg samples sw every clk.
- Mode latch: mode_reg samples mode only on the p_tick where h=H_TOTAL-1 and v=V_TOTAL-1, so modes never change mid-frame (no tearing).
- frame_start:
  - Pulses high for exactly one clk on that same p_tick.
  - Low at all other times.
- Mode 0 (solid): rgb = sw_reg.
- Mode 1 (colour bars):
  - Bar index b = h*8/H_ACTIVE, in range 0..7.
  - R channel is all ones if b[2], G if b[1], B if b[0]; otherwise all zeros.
- Mode 2 (checkerboard):
  - Cell parity = h[5]^v[5] (32x32 cells).
  - Parity 0 → sw_reg; parity 1 → ~sw_reg.
- Mode 3 (bouncing box):
  - rgb = sw_reg inside [bx,bx+BOX_SIZE-1] × [by,by+BOX_SIZE-1]; 0 elsewhere.
  - Position updates once per frame, at the frame_start tick.
  - x step: if dx=+ and bx=H_ACTIVE-BOX_SIZE, flip dx to − and step −1; if dx=− and bx=0, flip to + and step +1; otherwise step by dx.
  - y axis behaves identically using V_ACTIVE.
  - The box keeps moving in all modes, so switching into mode 3 shows its current position.
- Reset mid-frame: outputs return to reset values immediately; counting restarts at (0,0) after reset deasserts.
- Widths: counters sized by $clog2 of H_TOTAL and V_TOTAL; the bar-index multiply is done at full width with no overflow.

Optional Feature:
- Macro: VGA_BORDER_EN.
- Defined: when video_on and (h=0 || h=H_ACTIVE-1 || v=0 || v=V_ACTIVE-1), rgb is forced to all ones in every mode, overriding the pattern.
- Undefined: no border logic; rgb is exactly the selected pattern.

Test Plan:
- Reset, then run with TICK_DIV=2 → hsync low for 192 clk out of every 1600; vsync low for 2 lines (3200 clk) per 840000-clk frame; frame_start pulses once per 840000 clk.
- mode=0, sw=3'b101 → rgb=3'b101 while video_on=1; rgb=0 during porches and sync.
- mode=1 → pixel x=0 gives 3'b000, x=80 gives 3'b001, x=639 gives 3'b111.
- mode=2, sw=3'b110 → (0,0) gives 3'b110, (32,0) gives 3'b001, (32,32) gives 3'b110.
- mode=3 over 700 frames → box x reaches 608, reverses, and decrements; y reverses at 448; mode changed mid-frame takes effect only after the next frame_start.
- Assert reset at h=300, v=200 → hsync=vsync=1, rgb=0, video_on=0 immediately; the first frame_start occurs exactly 840000 clk after release; with VGA_BORDER_EN, pixel (0,0) is 3'b111 in mode 0 with sw=0.
